// File: rtl/nios_system_pio_edge_irq_if.sv
// Avalon-MM slave bus bundle for the edge-capture input PIO.
interface nios_system_pio_edge_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_pio_edge_irq.sv
// Input PIO with per-channel synchroniser, edge capture (W1C) and masked IRQ.
// Optional debouncer enabled by defining PIO_DEBOUNCE_EN.
module nios_system_pio_edge_irq #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned IDLE_LEVEL      = 1,
    parameter logic [1:0]  RESET_EDGE_SEL  = 2'b00,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nios_system_pio_edge_irq_if.slave    bus,
    input  logic [WIDTH-1:0]             in_port,
    output logic                         irq
);

    localparam logic             IDLE_BIT = logic'(IDLE_LEVEL & 1);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_BIT}};

    if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("nios_system_pio_edge_irq: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 1");
    end

    logic [WIDTH-1:0] s1_p0;
    logic [WIDTH-1:0] s2_p1;
    logic [WIDTH-1:0] stable_p2;
    logic [WIDTH-1:0] stable_d_p3;
    logic [1:0]       edge_sel;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_qual;
    logic [WIDTH-1:0] capture_clr;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wd;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign unused_wd = ^bus.writedata;

    // Stage 0/1: two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_p0 <= IDLE_VEC;
            s2_p1 <= IDLE_VEC;
        end else begin
            s1_p0 <= in_port;
            s2_p1 <= s1_p0;
        end
    end

    // Stage 2: accepted (optionally debounced) level
`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
            stable_p2 <= IDLE_VEC;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                // Any return to the accepted level restarts the stability window
                if (s2_p1[i] == stable_p2[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable_p2[i] <= s2_p1[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_p2 <= IDLE_VEC;
        end else begin
            stable_p2 <= s2_p1;
        end
    end
`endif

    // Stage 3: delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d_p3 <= IDLE_VEC;
        end else begin
            stable_d_p3 <= stable_p2;
        end
    end

    assign rise = stable_p2 & ~stable_d_p3;
    assign fall = ~stable_p2 & stable_d_p3;

    always_comb begin
        edge_qual = '0;
        case (edge_sel)
            2'b00:   edge_qual = rise;
            2'b01:   edge_qual = fall;
            2'b10:   edge_qual = rise | fall;
            default: edge_qual = '0;
        endcase
    end

    always_comb begin
        capture_clr = '0;
        if (wr_en && bus.address == 2'd3) capture_clr = bus.writedata[WIDTH-1:0];
    end

    // Stage 4: control registers and edge capture; a new edge beats a W1C
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_sel     <= RESET_EDGE_SEL;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr_en && bus.address == 2'd1) edge_sel <= bus.writedata[1:0];
            if (wr_en && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
            edge_capture <= (edge_capture & ~capture_clr) | edge_qual;
        end
    end

    assign irq = |(edge_capture & irq_mask);

    always_comb begin
        rd_next = '0;
        case (bus.address)
            2'd0:    rd_next[WIDTH-1:0] = stable_p2;
            2'd1:    rd_next[1:0]       = edge_sel;
            2'd2:    rd_next[WIDTH-1:0] = irq_mask;
            default: rd_next[WIDTH-1:0] = edge_capture;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_nios_system_pio_edge_irq.sv
// Directed bench for nios_system_pio_edge_irq (default build and PIO_DEBOUNCE_EN build).
module tb_nios_system_pio_edge_irq;

    localparam int DB_CYCLES = 16;
`ifdef PIO_DEBOUNCE_EN
    localparam int CAP_LAT = 3 + DB_CYCLES;
`else
    localparam int CAP_LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = 4'hF;
    logic       irq;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [31:0] rd;
    logic        irq_seen;

    nios_system_pio_edge_irq_if bif ();

    nios_system_pio_edge_irq #(
        .WIDTH           (4),
        .IDLE_LEVEL      (1),
        .RESET_EDGE_SEL  (2'b00),
        .DEBOUNCE_CYCLES (DB_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bif.address    = a;
        bif.writedata  = d;
        bif.chipselect = 1'b1;
        bif.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bif.chipselect = 1'b0;
        bif.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bif.address = a;
        @(posedge clk);
        #1 d = bif.readdata;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bif.address    = 2'd0;
        bif.chipselect = 1'b0;
        bif.write_n    = 1'b1;
        bif.writedata  = '0;
        wait_clks(3);
        reset_n = 1'b1;

        // Reset state and quiet period
        bus_read(2'd0, rd);  check_eq("data_after_reset", rd, 32'h0000000F);
        irq_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            irq_seen |= irq;
        end
        check_eq("irq_quiet_100", {31'b0, irq_seen}, 32'h0);
        bus_read(2'd3, rd);  check_eq("capture_reset", rd, 32'h0);
        bus_read(2'd1, rd);  check_eq("edge_sel_reset", rd, 32'h0);
        bus_read(2'd2, rd);  check_eq("mask_reset", rd, 32'h0);

        // Rising-edge mode on bit1
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'h2);
        @(negedge clk) in_port[1] = 1'b0;
        wait_clks(20);
        bus_read(2'd3, rd);  check_eq("rise_mode_ignores_fall", rd, 32'h0);
        check_eq("irq_after_fall", {31'b0, irq}, 32'h0);
        @(negedge clk) in_port[1] = 1'b1;
        wait_clks(20);
        bus_read(2'd3, rd);  check_eq("rise_capture", rd, 32'h2);
        check_eq("irq_rise", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h2);
        check_eq("irq_after_w1c", {31'b0, irq}, 32'h0);
        bus_read(2'd3, rd);  check_eq("capture_after_w1c", rd, 32'h0);

        // Both-edge mode, masked then unmasked
        bus_write(2'd1, 32'h2);
        bus_write(2'd2, 32'h0);
        @(negedge clk) in_port[0] = 1'b0;
        wait_clks(20);
        @(negedge clk) in_port[0] = 1'b1;
        wait_clks(20);
        bus_read(2'd3, rd);  check_eq("both_capture", rd, 32'h1);
        check_eq("irq_masked", {31'b0, irq}, 32'h0);
        bus_write(2'd2, 32'h1);
        check_eq("irq_unmasked", {31'b0, irq}, 32'h1);

        // Edge and W1C in the same cycle on bit2: the set wins
        bus_write(2'd1, 32'h0);
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h4);
        @(negedge clk) in_port[2] = 1'b0;
        wait_clks(20);
        bus_read(2'd3, rd);  check_eq("pre_simul_capture", rd, 32'h0);
        @(negedge clk) in_port[2] = 1'b1;
        repeat (CAP_LAT - 2) @(negedge clk);
        bus_write(2'd3, 32'h4);
        check_eq("irq_simul", {31'b0, irq}, 32'h1);
        bus_read(2'd3, rd);  check_eq("simul_set_wins", rd, 32'h4);
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, rd);  check_eq("w1c_zero_no_effect", rd, 32'h4);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, rd);  check_eq("w1c_bit2", rd, 32'h0);

        // Falling-edge mode on bit0
        bus_write(2'd1, 32'h1);
        @(negedge clk) in_port[0] = 1'b0;
        wait_clks(20);
        bus_read(2'd3, rd);  check_eq("fall_capture", rd, 32'h1);
        @(negedge clk) in_port[0] = 1'b1;
        wait_clks(20);
        bus_write(2'd3, 32'hF);

        // Edge detection off; DATA is read-only
        bus_write(2'd1, 32'h3);
        bus_read(2'd1, rd);  check_eq("edge_sel_off_rb", rd, 32'h3);
        @(negedge clk) in_port[1] = 1'b0;
        wait_clks(20);
        bus_read(2'd0, rd);  check_eq("data_bit1_low", rd, 32'hD);
        @(negedge clk) in_port[1] = 1'b1;
        wait_clks(20);
        bus_read(2'd3, rd);  check_eq("off_no_capture", rd, 32'h0);
        bus_write(2'd0, 32'h0);
        bus_read(2'd0, rd);  check_eq("data_write_ignored", rd, 32'hF);

`ifdef PIO_DEBOUNCE_EN
        // Debounce: short glitch rejected, long hold accepted
        bus_write(2'd1, 32'h1);
        bus_write(2'd3, 32'hF);
        @(negedge clk) in_port[3] = 1'b0;
        wait_clks(10);
        @(negedge clk) in_port[3] = 1'b1;
        wait_clks(25);
        bus_read(2'd3, rd);  check_eq("glitch_no_capture", rd, 32'h0);
        bus_read(2'd0, rd);  check_eq("glitch_data", rd, 32'hF);
        @(negedge clk) in_port[3] = 1'b0;
        wait_clks(20);
        bus_read(2'd0, rd);  check_eq("hold_data", rd, 32'h7);
        bus_read(2'd3, rd);  check_eq("hold_capture", rd, 32'h8);
        @(negedge clk) in_port[3] = 1'b1;
        wait_clks(25);
`endif

        // Reset while captures and irq are pending
        bus_write(2'd1, 32'h2);
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'hF);
        @(negedge clk) in_port = 4'h0;
        wait_clks(25);
        bus_read(2'd3, rd);  check_eq("all_captured", rd, 32'hF);
        check_eq("irq_all", {31'b0, irq}, 32'h1);
        @(negedge clk) in_port = 4'hF;
        wait_clks(25);
        #2 reset_n = 1'b0;
        #1;
        check_eq("irq_in_reset", {31'b0, irq}, 32'h0);
        check_eq("readdata_in_reset", bif.readdata, 32'h0);
        wait_clks(2);
        reset_n = 1'b1;
        wait_clks(10);
        bus_read(2'd3, rd);  check_eq("capture_after_rst", rd, 32'h0);
        bus_read(2'd1, rd);  check_eq("edge_sel_after_rst", rd, 32'h0);
        bus_read(2'd2, rd);  check_eq("mask_after_rst", rd, 32'h0);
        check_eq("irq_after_rst", {31'b0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
